// File: rtl/exec_pkg.sv
// Shared op/branch codes, FSM state encoding and a log2 helper for the
// pipelined execute stage.
package exec_pkg;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_ANDN = 4'd3;
    localparam logic [3:0] OP_ROL  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SEQ  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLE  = 4'd10;
    localparam logic [3:0] OP_SCO  = 4'd11;
    localparam logic [3:0] OP_BTR  = 4'd12;
    localparam logic [3:0] OP_LBI  = 4'd13;
    localparam logic [3:0] OP_SLBI = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQZ  = 3'd1;
    localparam logic [2:0] BR_NEZ  = 3'd2;
    localparam logic [2:0] BR_LTZ  = 3'd3;
    localparam logic [2:0] BR_GEZ  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int lg2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle;
// last_o flags the edge on which the final partial product is accumulated.
module exec_mul_iter import exec_pkg::*; #(
    parameter int DATA_W  = 16,
    parameter int MUL_BPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              last_o,
    output logic [DATA_W-1:0] prod_o
);
    localparam int STEPS = DATA_W / MUL_BPC;
    localparam int CW    = lg2(STEPS) + 1;

    logic              active_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] acc_q, mcand_q, mplier_q, partial;

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BPC; i++)
            if (mplier_q[i]) partial = partial + (mcand_q << i);
    end

    assign last_o = active_q && (cnt_q == CW'(STEPS - 1));
    assign prod_o = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (kill_i) begin
            active_q <= 1'b0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (active_q) begin
            acc_q    <= acc_q + partial;
            mcand_q  <= mcand_q << MUL_BPC;
            mplier_q <= mplier_q >> MUL_BPC;
            cnt_q    <= cnt_q + 1'b1;
            if (last_o) active_q <= 1'b0;
        end
    end
endmodule

// File: rtl/exec_stage_pipe.sv
// Registered execute stage: ALU, branch/jump redirect, valid/ready output register.
// Define EXEC_MUL_EN to build the multi-cycle multiplier (op 15); otherwise op 15 is illegal.
module exec_stage_pipe import exec_pkg::*; #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3,
    parameter int MUL_BPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_src_imm,
    input  logic [DATA_W-1:0] in_pc_next,
    input  logic [2:0]        in_br,
    input  logic              in_jmp,
    input  logic              in_jmp_reg,
    input  logic              in_link,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_wr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_wr_en,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              busy,
    output logic              err
);
    localparam int SHW = lg2(DATA_W);

    state_e            state_q;
    logic              out_valid_q, out_wr_en_q, err_q, redir_q;
    logic [DATA_W-1:0] out_result_q, redir_pc_q;
    logic [REG_AW-1:0] out_dest_q;

    logic [DATA_W-1:0] opb, alu_res, res_d, tgt_d, mul_prod;
    logic [SHW-1:0]    sh;
    logic [SHW:0]      inv_sh;
    logic [DATA_W:0]   sum_c;
    logic              br_take, redir_d, illegal, is_mul, accept, load_mul, mul_wr;
    logic [REG_AW-1:0] mul_dest;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        opb     = in_src_imm ? in_imm : in_b;
        sh      = opb[SHW-1:0];
        inv_sh  = (SHW+1)'(DATA_W) - {1'b0, sh};
        sum_c   = {1'b0, in_a} + {1'b0, opb};
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = sum_c[DATA_W-1:0];
            OP_SUB:  alu_res = opb - in_a;
            OP_XOR:  alu_res = in_a ^ opb;
            OP_ANDN: alu_res = in_a & ~opb;
            OP_ROL:  alu_res = (in_a << sh) | (in_a >> inv_sh);
            OP_SLL:  alu_res = in_a << sh;
            OP_ROR:  alu_res = (in_a >> sh) | (in_a << inv_sh);
            OP_SRL:  alu_res = in_a >> sh;
            OP_SEQ:  alu_res = {{(DATA_W-1){1'b0}}, in_a == opb};
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(in_a) < $signed(opb)};
            OP_SLE:  alu_res = {{(DATA_W-1){1'b0}}, $signed(in_a) <= $signed(opb)};
            OP_SCO:  alu_res = {{(DATA_W-1){1'b0}}, sum_c[DATA_W]};
            OP_BTR:  for (int i = 0; i < DATA_W; i++) alu_res[i] = in_a[DATA_W-1-i];
            OP_LBI:  alu_res = opb;
            OP_SLBI: alu_res = (in_a << 8) | {{(DATA_W-8){1'b0}}, opb[7:0]};
            default: alu_res = '0;
        endcase

        case (in_br)
            BR_EQZ:  br_take = (in_a == '0);
            BR_NEZ:  br_take = (in_a != '0);
            BR_LTZ:  br_take = in_a[DATA_W-1];
            BR_GEZ:  br_take = !in_a[DATA_W-1];
            default: br_take = 1'b0;
        endcase

`ifdef EXEC_MUL_EN
        illegal = (in_br > BR_GEZ);
`else
        illegal = (in_br > BR_GEZ) || (in_op == OP_MUL);
`endif
        res_d   = illegal ? '0 : (in_link ? in_pc_next : alu_res);
        redir_d = !illegal && (br_take || in_jmp || in_jmp_reg);
        tgt_d   = in_jmp_reg ? in_a + in_imm : in_pc_next + in_imm;
    end

`ifdef EXEC_MUL_EN
    logic              busy_q, mul_last, mul_wr_q;
    logic [REG_AW-1:0] mul_dest_q;

    assign is_mul   = (in_op == OP_MUL) && !illegal;
    assign load_mul = (state_q == ST_DONE) && (!out_valid_q || out_ready);
    assign mul_dest = mul_dest_q;
    assign mul_wr   = mul_wr_q;
    assign busy     = busy_q;

    exec_mul_iter #(.DATA_W(DATA_W), .MUL_BPC(MUL_BPC)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && is_mul),
        .kill_i  (flush),
        .a_i     (in_a),
        .b_i     (opb),
        .last_o  (mul_last),
        .prod_o  (mul_prod)
    );
`else
    assign is_mul   = 1'b0;
    assign load_mul = 1'b0;
    assign mul_prod = '0;
    assign mul_dest = '0;
    assign mul_wr   = 1'b0;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_wr_en_q  <= 1'b0;
            err_q        <= 1'b0;
            out_result_q <= '0;
            out_dest_q   <= '0;
            redir_q      <= 1'b0;
            redir_pc_q   <= '0;
`ifdef EXEC_MUL_EN
            busy_q       <= 1'b0;
            mul_wr_q     <= 1'b0;
            mul_dest_q   <= '0;
`endif
        end else begin
            // accept is already gated by flush, so a flushed op never redirects
            redir_q <= accept && redir_d;
            if (accept && redir_d) redir_pc_q <= tgt_d;

            if (flush) begin
                out_valid_q <= 1'b0;
                out_wr_en_q <= 1'b0;
                err_q       <= 1'b0;
            end else if (accept && !is_mul) begin
                out_valid_q  <= 1'b1;
                out_result_q <= res_d;
                out_dest_q   <= in_dest;
                out_wr_en_q  <= in_wr_en && !illegal;
                err_q        <= illegal;
            end else if (load_mul) begin
                out_valid_q  <= 1'b1;
                out_result_q <= mul_prod;
                out_dest_q   <= mul_dest;
                out_wr_en_q  <= mul_wr;
                err_q        <= 1'b0;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_wr_en_q <= 1'b0;
                err_q       <= 1'b0;
            end

`ifdef EXEC_MUL_EN
            if (flush) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (accept && is_mul) begin
                        state_q    <= ST_MUL;
                        busy_q     <= 1'b1;
                        mul_dest_q <= in_dest;
                        mul_wr_q   <= in_wr_en;
                    end
                    ST_MUL: if (mul_last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                    end
                    ST_DONE: if (load_mul) state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
`endif
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_dest       = out_dest_q;
    assign out_wr_en      = out_wr_en_q;
    assign err            = err_q;
    assign redirect_valid = redir_q;
    assign redirect_pc    = redir_pc_q;
endmodule

// File: tb/tb_exec_stage_pipe.sv
// Directed bench for exec_stage_pipe; covers the multiplier or its illegal-op
// path depending on whether EXEC_MUL_EN is defined.
module tb_exec_stage_pipe;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic          in_src_imm = 1'b0, in_jmp = 1'b0, in_jmp_reg = 1'b0, in_link = 1'b0;
    logic          in_wr_en = 1'b0, out_ready = 1'b1;
    logic [3:0]    in_op = '0;
    logic [2:0]    in_br = '0;
    logic [DW-1:0] in_a = '0, in_b = '0, in_imm = '0, in_pc_next = '0;
    logic [AW-1:0] in_dest = '0;
    logic          in_ready, out_valid, out_wr_en, redirect_valid, busy, err;
    logic [DW-1:0] out_result, redirect_pc;
    logic [AW-1:0] out_dest;

    int pass_cnt = 0;
    int total_cnt = 0;

    exec_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .MUL_BPC(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_src_imm(in_src_imm),
        .in_pc_next(in_pc_next), .in_br(in_br), .in_jmp(in_jmp), .in_jmp_reg(in_jmp_reg),
        .in_link(in_link), .in_dest(in_dest), .in_wr_en(in_wr_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_dest(out_dest),
        .out_wr_en(out_wr_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_imm = 0; in_src_imm = 0;
        in_pc_next = 0; in_br = 0; in_jmp = 0; in_jmp_reg = 0; in_link = 0;
        in_dest = 0; in_wr_en = 0;
    endtask

    task automatic test_reset;
        #12;
        total_cnt++; if ({out_valid, out_wr_en, redirect_valid, busy, err} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {out_valid, out_wr_en, redirect_valid, busy, err}); else pass_cnt++;
        total_cnt++; if ({out_result, redirect_pc, out_dest} !== '0) $display("FAIL reset_data: got %h/%h/%h want 0", out_result, redirect_pc, out_dest); else pass_cnt++;
        @(negedge clk) rst = 1'b0;
        step();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_add;
        clr_in();
        in_op = 4'd0; in_a = 16'h7FFF; in_b = 16'h0001; in_dest = 3'd3; in_wr_en = 1; in_valid = 1;
        step();
        in_valid = 0;
        total_cnt++; if ({out_valid, out_wr_en} !== 2'b11) $display("FAIL add_valid: got %b want 11", {out_valid, out_wr_en}); else pass_cnt++;
        total_cnt++; if (out_result !== 16'h8000) $display("FAIL add_result: got %h want 8000", out_result); else pass_cnt++;
        total_cnt++; if (out_dest !== 3'd3) $display("FAIL add_dest: got %0d want 3", out_dest); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL add_drain: got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_branch;
        clr_in();
        in_a = 16'h0003; in_pc_next = 16'h0010; in_imm = 16'hFFF8; in_br = 3'd2; in_valid = 1;
        step();
        in_valid = 0;
        total_cnt++; if ({redirect_valid, redirect_pc} !== {1'b1, 16'h0008}) $display("FAIL nez_taken: got %b/%h want 1/0008", redirect_valid, redirect_pc); else pass_cnt++;
        step();
        total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL nez_pulse: got %b want 0", redirect_valid); else pass_cnt++;
        in_a = 16'h0000; in_valid = 1;
        step();
        in_valid = 0;
        total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL nez_not_taken: got %b want 0", redirect_valid); else pass_cnt++;
    endtask

    task automatic test_jmp_link;
        clr_in();
        in_jmp_reg = 1; in_link = 1; in_a = 16'h0100; in_imm = 16'h0004; in_pc_next = 16'h0042;
        in_wr_en = 1; in_dest = 3'd7; in_valid = 1;
        step();
        clr_in();
        total_cnt++; if ({redirect_valid, redirect_pc} !== {1'b1, 16'h0104}) $display("FAIL jr_target: got %b/%h want 1/0104", redirect_valid, redirect_pc); else pass_cnt++;
        total_cnt++; if ({out_valid, out_result} !== {1'b1, 16'h0042}) $display("FAIL jr_link: got %b/%h want 1/0042", out_valid, out_result); else pass_cnt++;
        step();
    endtask

    task automatic test_backpressure;
        clr_in();
        out_ready = 0;
        in_a = 16'h0001; in_b = 16'h0002; in_valid = 1;
        step();
        in_a = 16'h0005; in_b = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if ({out_valid, in_ready, out_result} !== {2'b10, 16'h0003}) $display("FAIL bp_hold%0d: got %b%b/%h want 10/0003", i, out_valid, in_ready, out_result); else pass_cnt++;
            step();
        end
        out_ready = 1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", in_ready); else pass_cnt++;
        step();
        in_valid = 0;
        total_cnt++; if ({out_valid, out_result} !== {1'b1, 16'h000A}) $display("FAIL bp_next: got %b/%h want 1/000a", out_valid, out_result); else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back;
        logic [3:0]    ops [15] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd0};
        logic [DW-1:0] av  [15] = '{16'h0003, 16'hF0F0, 16'hFF0F, 16'h8001, 16'h0001, 16'h0001, 16'h8000, 16'h1234, 16'hFFFF, 16'h0005, 16'hFFFF, 16'h0001, 16'h0000, 16'h0012, 16'h0005};
        logic [DW-1:0] bv  [15] = '{16'h000A, 16'hFF00, 16'h00FF, 16'h0011, 16'h0004, 16'h0001, 16'h000F, 16'h1234, 16'h0001, 16'h0004, 16'h0001, 16'h0000, 16'h1234, 16'h0034, 16'h0003};
        logic          si  [15] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        logic [DW-1:0] exp [15] = '{16'h0007, 16'h0FF0, 16'hFF00, 16'h0003, 16'h0010, 16'h8000, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h1234, 16'h1234, 16'h0008};
        clr_in();
        for (int i = 0; i < 15; i++) begin
            in_op = ops[i]; in_a = av[i]; in_src_imm = si[i];
            in_b   = si[i] ? 16'hFFFF : bv[i];
            in_imm = si[i] ? bv[i] : 16'hFFFF;
            in_valid = 1;
            step();
            total_cnt++; if ({out_valid, out_result} !== {1'b1, exp[i]}) $display("FAIL op%0d_result: got %b/%h want 1/%h", ops[i], out_valid, out_result, exp[i]); else pass_cnt++;
        end
        clr_in();
        step();
    endtask

    task automatic test_illegal_br;
        clr_in();
        in_br = 3'd5; in_jmp = 1; in_a = 16'h0001; in_b = 16'h0001; in_wr_en = 1; in_valid = 1;
        step();
        clr_in();
        total_cnt++; if ({out_valid, err, out_wr_en} !== 3'b110) $display("FAIL illegal_br_flags: got %b want 110", {out_valid, err, out_wr_en}); else pass_cnt++;
        total_cnt++; if ({redirect_valid, out_result} !== {1'b0, 16'h0000}) $display("FAIL illegal_br_data: got %b/%h want 0/0000", redirect_valid, out_result); else pass_cnt++;
        step();
        total_cnt++; if (err !== 1'b0) $display("FAIL illegal_br_clear: got %b want 0", err); else pass_cnt++;
    endtask

    task automatic test_flush;
        clr_in();
        out_ready = 0;
        in_a = 16'h0002; in_b = 16'h0002; in_valid = 1;
        step();
        in_jmp = 1; in_imm = 16'h0020; flush = 1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_blocks_accept: got %b want 0", in_ready); else pass_cnt++;
        step();
        flush = 0; clr_in(); out_ready = 1;
        total_cnt++; if ({out_valid, redirect_valid} !== 2'b00) $display("FAIL flush_clear: got %b want 00", {out_valid, redirect_valid}); else pass_cnt++;
        step();
    endtask

`ifdef EXEC_MUL_EN
    task automatic test_mul;
        int cyc;
        int k;
        int seen;
        clr_in();
        in_op = 4'd15; in_a = 16'h0123; in_b = 16'h0045; in_wr_en = 1; in_dest = 3'd5; in_valid = 1;
        step();
        clr_in();
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin cyc++; step(); end
        total_cnt++; if (cyc !== 16) $display("FAIL mul_busy_cycles: got %0d want 16", cyc); else pass_cnt++;
        k = 0;
        while (out_valid !== 1'b1 && k < 5) begin k++; step(); end
        total_cnt++; if (k !== 1) $display("FAIL mul_done_latency: got %0d want 1", k); else pass_cnt++;
        total_cnt++; if ({out_result, out_wr_en, out_dest} !== {16'h4E6F, 1'b1, 3'd5}) $display("FAIL mul_result: got %h/%b/%0d want 4e6f/1/5", out_result, out_wr_en, out_dest); else pass_cnt++;
        step();
        in_op = 4'd15; in_a = 16'h0123; in_b = 16'h0045; in_valid = 1;
        step();
        clr_in();
        repeat (4) step();
        flush = 1;
        step();
        flush = 0;
        total_cnt++; if ({busy, out_valid, in_ready} !== 3'b001) $display("FAIL mul_flush: got %b want 001", {busy, out_valid, in_ready}); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin if (out_valid === 1'b1) seen++; step(); end
        total_cnt++; if (seen !== 0) $display("FAIL mul_flush_no_result: got %0d want 0", seen); else pass_cnt++;
    endtask

    task automatic test_async_rst;
        int seen;
        clr_in();
        in_op = 4'd15; in_a = 16'h0123; in_b = 16'h0045; in_jmp = 1; in_imm = 16'h0010; in_valid = 1;
        step();
        clr_in();
        repeat (4) step();
        total_cnt++; if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy); else pass_cnt++;
        #2 rst = 1;
        #1;
        total_cnt++; if ({busy, out_valid, redirect_valid, err, out_result, redirect_pc} !== '0) $display("FAIL rst_async: got %b%b%b%b/%h/%h want 0", busy, out_valid, redirect_valid, err, out_result, redirect_pc); else pass_cnt++;
        @(negedge clk) rst = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin if (out_valid === 1'b1 || busy === 1'b1) seen++; step(); end
        total_cnt++; if (seen !== 0) $display("FAIL rst_discard: got %0d want 0", seen); else pass_cnt++;
    endtask
`else
    task automatic test_mul;
        clr_in();
        in_op = 4'd15; in_a = 16'h0003; in_b = 16'h0003; in_wr_en = 1; in_valid = 1;
        step();
        clr_in();
        total_cnt++; if ({out_valid, err, out_wr_en, busy} !== 4'b1100) $display("FAIL mul_illegal_flags: got %b want 1100", {out_valid, err, out_wr_en, busy}); else pass_cnt++;
        total_cnt++; if (out_result !== 16'h0000) $display("FAIL mul_illegal_result: got %h want 0000", out_result); else pass_cnt++;
        step();
    endtask

    task automatic test_async_rst;
        clr_in();
        out_ready = 0;
        in_jmp = 1; in_a = 16'h0011; in_b = 16'h0022; in_imm = 16'h0030; in_pc_next = 16'h0002; in_dest = 3'd2; in_valid = 1;
        step();
        clr_in();
        total_cnt++; if ({out_valid, redirect_valid, out_result} !== {2'b11, 16'h0033}) $display("FAIL rst_pre: got %b%b/%h want 11/0033", out_valid, redirect_valid, out_result); else pass_cnt++;
        #2 rst = 1;
        #1;
        total_cnt++; if ({out_valid, redirect_valid, out_result, redirect_pc, out_dest} !== '0) $display("FAIL rst_async: got %b%b/%h/%h/%0d want 0", out_valid, redirect_valid, out_result, redirect_pc, out_dest); else pass_cnt++;
        @(negedge clk) rst = 0;
        out_ready = 1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_jmp_link();
        test_backpressure();
        test_back_to_back();
        test_illegal_br();
        test_flush();
        test_mul();
        test_async_rst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/exec_stage_pipe.md
Name: exec_stage_pipe

Overview:
- Parametrised, registered successor to the single-cycle execute stage; sits between the ID/EX and EX/MEM boundaries of the pipelined core.
- Performs ALU ops, resolves branches and jumps into a one-cycle redirect pulse, and holds results in an output register under a valid/ready handshake.
- Adds a stall-able, flushable multi-cycle shift-add multiplier.

Parameters:
- DATA_W, 16, datapath width; must be ≥8 and a power of 2.
- REG_AW, 3, destination register index width.
- MUL_BPC, 1, multiplier bits retired per cycle; must divide DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  kills the in-flight op and the output register.
- in_valid  in  1  upstream holds a valid op.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  4  op code: 0 ADD, 1 SUB (b−a), 2 XOR, 3 ANDN, 4 ROL, 5 SLL, 6 ROR, 7 SRL, 8 SEQ, 9 SLT, 10 SLE, 11 SCO, 12 BTR, 13 LBI, 14 SLBI, 15 MUL.
- in_a, in_b, in_imm  in  DATA_W  operands; in_imm is already extended.
- in_src_imm  in  1  second operand = in_imm instead of in_b.
- in_pc_next  in  DATA_W  PC+2 of this instruction.
- in_br  in  3  branch condition: 0 none, 1 EQZ, 2 NEZ, 3 LTZ, 4 GEZ; 5–7 illegal.
- in_jmp, in_jmp_reg, in_link  in  1 each  PC-relative jump, register jump, link write.
- in_dest  in  REG_AW  destination register.
- in_wr_en  in  1  op writes the register file.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_result  out  DATA_W  result.
- out_dest  out  REG_AW  destination register.
- out_wr_en  out  1  write enable for the result.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  DATA_W  redirect target.
- busy  out  1  multiplier active.
- err  out  1  illegal op; aligned with out_valid.

Behaviour:
- Reset: state IDLE. out_valid, out_wr_en, redirect_valid, busy, err = 0. out_result, redirect_pc, out_dest = 0.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Output register: holds stable while out_valid && !out_ready. Cleared by a handshake with no new load, or by flush.
- Single-cycle ops: result registered on the accept edge, so out_valid rises the next cycle (latency 1). Back-to-back throughput is 1 op/cycle.
- Second operand: B = in_src_imm ? in_imm : in_b.
- Arithmetic: modulo 2^DATA_W.
- Shifts/rotates: amount = B[log2(DATA_W)−1:0].
- SCO: carry out of a+B. SLT/SLE: signed compare.
- BTR: bit reverse of a. LBI: result = B. SLBI: (a << 8) | B[7:0].
- Branch: condition tested on in_a. If taken, redirect_pc = in_pc_next + in_imm.
- Jumps: in_jmp gives target in_pc_next + in_imm; in_jmp_reg gives target in_a + in_imm.
- Redirect: redirect_valid pulses exactly one cycle, the cycle after accept, independent of out_ready.
- Link: in_link forces result = in_pc_next.
- MUL: FSM IDLE→MUL on accept; busy=1. MUL_BPC multiplier bits are consumed per cycle; the counter runs DATA_W/MUL_BPC cycles. The product is the low DATA_W bits. Then MUL→DONE.
- DONE: loads the output register when !out_valid || out_ready, then returns to IDLE.
- Total MUL latency: DATA_W/MUL_BPC + 1 cycles minimum.
- Flush: any state→IDLE; out_valid and redirect_valid forced 0 next cycle.
- Flush vs accept: flush wins; no accept in the same cycle.
- Illegal op (in_br 5–7, or MUL when the multiplier is compiled out): result 0, out_wr_en = 0, err = 1 with out_valid, no redirect.
- Async reset mid-MUL: drops immediately to the reset values above; the partial product is discarded.

Optional Feature:
- EXEC_MUL_EN defined: multiplier and the MUL/DONE states are built.
- Undefined: op 15 is illegal (err path, latency 1); busy is tied to 0.

Decomposition:
- Shared package exec_pkg holds: op-code and branch-code localparams, FSM state encodings, and a log2 helper function.
- One natural sub-module: exec_mul_iter, the shift-add core with start/done handshake and MUL_BPC parameter.

Test Plan:
- ADD: a=0x7FFF, b=0x0001, src_imm=0 → next cycle out_valid=1, out_result=0x8000, out_wr_en=1.
- Branch NEZ: a=0x0003, pc_next=0x0010, imm=0xFFF8 → single-cycle redirect_valid, redirect_pc=0x0008. With a=0 → no redirect.
- Register jump with link: in_jmp_reg=1, in_link=1, a=0x0100, imm=0x0004, pc_next=0x0042 → redirect_pc=0x0104, out_result=0x0042.
- Backpressure: out_ready=0 for 3 cycles after a result → out_result stable, in_ready=0; releasing out_ready accepts the next op the same cycle.
- MUL (EXEC_MUL_EN, MUL_BPC=1): a=0x0123, b=0x0045 → busy for 16 cycles, out_result=0x4E6F; a flush at cycle 5 → IDLE, no out_valid.
- Async rst asserted mid-MUL → all outputs 0 immediately. Without EXEC_MUL_EN, op 15 → err=1, out_wr_en=0 after 1 cycle.
